// File: rtl/int_to_fp_if.sv
// Start/done handshake bundle shared by the integer-to-float converter and its client.
interface int_to_fp_if;
   logic        start;
   logic [31:0] int_in;
   logic        is_signed;
   logic [31:0] result;
   logic        done;
   logic        busy;
   logic        inexact;

   modport master (
      output start, int_in, is_signed,
      input  result, done, busy, inexact
   );

   modport slave (
      input  start, int_in, is_signed,
      output result, done, busy, inexact
   );
endinterface

// File: rtl/int_to_fp.sv
// Multi-cycle 32-bit integer to IEEE 754 single conversion: one-bit-per-cycle
// normalisation followed by a single rounding cycle.
module int_to_fp #(
   parameter int ROUND_NEAREST = 1
) (
   input  logic      clk,
   input  logic      reset,
   int_to_fp_if.slave bus
);

   typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

   state_t      state;
   logic        sign;
   logic [31:0] mag;
   logic [7:0]  exp;

   logic               in_sign;
   logic signed [31:0] operand;
   logic [31:0]        in_mag;

   // Two's complement negate; 0x80000000 maps onto itself, the correct magnitude.
   assign operand = bus.int_in;
   assign in_sign = bus.is_signed & bus.int_in[31];
   assign in_mag  = in_sign ? 32'(-operand) : bus.int_in;

   // mag arrives normalised (bit 31 set); bit 31 is the hidden one.
   function automatic logic [31:0] round_pack(input logic s, input logic [7:0] e,
                                              input logic [31:0] m);
      logic [23:0] man;
      logic [7:0]  e_out;
      logic        guard;
      logic        sticky;
      man    = {1'b0, m[30:8]};
      guard  = m[7];
      sticky = |m[6:0];
      e_out  = e;
      if ((ROUND_NEAREST != 0) && guard && (sticky || m[8]))
         man = man + 24'd1;
      if (man[23]) begin
         man   = 24'd0;
         e_out = e + 8'd1;
      end
      return {s, e_out, man[22:0]};
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         sign        <= 1'b0;
         mag         <= 32'd0;
         exp         <= 8'd0;
         bus.result  <= 32'd0;
         bus.done    <= 1'b0;
         bus.busy    <= 1'b0;
         bus.inexact <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  sign <= in_sign;
                  mag  <= in_mag;
                  exp  <= 8'd158;
                  if (in_mag == 32'd0) begin
                     bus.result  <= 32'd0;
                     bus.inexact <= 1'b0;
                     bus.done    <= 1'b1;
                     state       <= DONE;
                  end else begin
                     bus.busy <= 1'b1;
                     state    <= NORM;
                  end
               end
            end
            NORM: begin
               if (mag[31]) begin
                  state <= ROUND;
               end else begin
                  mag <= mag << 1;
                  exp <= exp - 8'd1;
               end
            end
            ROUND: begin
               bus.result  <= round_pack(sign, exp, mag);
               bus.inexact <= |mag[7:0];
               bus.done    <= 1'b1;
               bus.busy    <= 1'b0;
               state       <= DONE;
            end
            DONE: begin
               // Level handshake: a held start never retriggers a conversion.
               if (!bus.start) begin
                  bus.done <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_int_to_fp.sv
// Self-checking bench: round-to-nearest and truncating converters driven in lockstep.
module tb_int_to_fp;
   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] int_in;
   logic        is_signed;

   int checks;
   int errors;

   int_to_fp_if bus_rn ();
   int_to_fp_if bus_tr ();

   assign bus_rn.start     = start;
   assign bus_rn.int_in    = int_in;
   assign bus_rn.is_signed = is_signed;
   assign bus_tr.start     = start;
   assign bus_tr.int_in    = int_in;
   assign bus_tr.is_signed = is_signed;

   int_to_fp #(.ROUND_NEAREST(1)) dut_rn (.clk(clk), .reset(reset), .bus(bus_rn));
   int_to_fp #(.ROUND_NEAREST(0)) dut_tr (.clk(clk), .reset(reset), .bus(bus_tr));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam int NDIR = 8;
   localparam logic [31:0] TX  [NDIR] = '{32'h00000001, 32'hFFFFFFFF, 32'h80000000, 32'h80000000,
                                          32'h01000001, 32'h01000003, 32'hFFFFFFFF, 32'h00000064};
   localparam bit          TS  [NDIR] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [31:0] TRN [NDIR] = '{32'h3F800000, 32'hBF800000, 32'hCF000000, 32'h4F000000,
                                          32'h4B800000, 32'h4B800002, 32'h4F800000, 32'h42C80000};
   localparam bit          TIX [NDIR] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
   localparam logic [31:0] TTR [NDIR] = '{32'h3F800000, 32'hBF800000, 32'hCF000000, 32'h4F000000,
                                          32'h4B800000, 32'h4B800001, 32'h4F7FFFFF, 32'h42C80000};
   localparam int          TLAT[NDIR] = '{33, 33, 2, 2, 9, 9, 2, 27};

   // Reference: exact value as an integer, scaled by 2^(e-23) with explicit
   // remainder-based tie handling; latency from the leading-zero count.
   function automatic void ref_conv(input logic [31:0] x, input bit sgn, input bit rne,
                                    output logic [31:0] r, output bit inx, output int lat);
      longint v, m, scale, q, rem;
      bit     neg;
      int     e;
      neg = sgn && x[31];
      v   = sgn ? longint'($signed(x)) : longint'({32'd0, x});
      m   = neg ? -v : v;
      if (m == 0) begin
         r = 32'd0; inx = 1'b0; lat = 1;
         return;
      end
      e = 0;
      while ((longint'(1) << (e + 1)) <= m) e++;
      lat = (31 - e) + 2;
      rem = 0;
      if (e > 23) begin
         scale = longint'(1) << (e - 23);
         q     = m / scale;
         rem   = m % scale;
         if (rne && ((2 * rem > scale) || (2 * rem == scale && q % 2 == 1))) q++;
      end else begin
         q = m << (23 - e);
      end
      if (q == (longint'(1) << 24)) begin
         q = q / 2;
         e++;
      end
      inx = (rem != 0);
      r   = {neg, 8'(e + 127), 23'(q - (longint'(1) << 23))};
   endfunction

   task automatic run_conv(input logic [31:0] x, input bit sgn, input bit scramble,
                           output int cycles, output bit busy_seen, output bit timed_out);
      @(negedge clk);
      int_in = x; is_signed = sgn; start = 1'b1;
      @(posedge clk);
      cycles = 0; busy_seen = 1'b0; timed_out = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         cycles++;
         if (bus_rn.busy) busy_seen = 1'b1;
         if (bus_rn.done) begin
            timed_out = 1'b0;
            break;
         end
         if (scramble) begin
            int_in = $urandom; is_signed = 1'($urandom_range(0, 1));
         end
      end
   endtask

   task automatic release_start();
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; int_in = 32'd0; is_signed = 1'b0;
      #12;
      checks++;
      if ({bus_rn.result, bus_rn.done, bus_rn.busy, bus_rn.inexact} !== 35'd0 ||
          {bus_tr.result, bus_tr.done, bus_tr.busy, bus_tr.inexact} !== 35'd0) begin
         errors++;
         $display("FAIL reset_state: got rn=%h/%b%b%b tr=%h want all zero",
                  bus_rn.result, bus_rn.done, bus_rn.busy, bus_rn.inexact, bus_tr.result);
      end
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic test_directed();
      int cyc; bit bs, to;
      for (int k = 0; k < NDIR; k++) begin
         run_conv(TX[k], TS[k], 1'b0, cyc, bs, to);
         checks++;
         if (to) begin
            errors++; $display("FAIL dir_timeout[%0d]: done never rose", k);
         end
         checks++;
         if (bus_rn.result !== TRN[k] || bus_rn.inexact !== TIX[k]) begin
            errors++;
            $display("FAIL dir_rne[%0d]: got %h inx %b want %h inx %b",
                     k, bus_rn.result, bus_rn.inexact, TRN[k], TIX[k]);
         end
         checks++;
         if (bus_tr.result !== TTR[k] || bus_tr.done !== 1'b1) begin
            errors++;
            $display("FAIL dir_trunc[%0d]: got %h done %b want %h", k, bus_tr.result, bus_tr.done, TTR[k]);
         end
         checks++;
         if (cyc != TLAT[k] || !bs) begin
            errors++;
            $display("FAIL dir_latency[%0d]: got %0d busy %b want %0d busy 1", k, cyc, bs, TLAT[k]);
         end
         release_start();
         checks++;
         if (bus_rn.done !== 1'b0 || bus_rn.result !== TRN[k]) begin
            errors++;
            $display("FAIL dir_release[%0d]: got done %b result %h want 0 %h", k, bus_rn.done, bus_rn.result, TRN[k]);
         end
      end
   endtask

   task automatic test_zero();
      int cyc; bit bs, to;
      run_conv(32'h00000000, 1'b1, 1'b0, cyc, bs, to);
      checks++;
      if (to || cyc != 1 || bs) begin
         errors++;
         $display("FAIL zero_timing: got cycles %0d busy %b timeout %b want 1 0 0", cyc, bs, to);
      end
      checks++;
      if (bus_rn.result !== 32'd0 || bus_rn.inexact !== 1'b0 || bus_tr.result !== 32'd0) begin
         errors++;
         $display("FAIL zero_result: got %h inx %b tr %h want 00000000 0", bus_rn.result, bus_rn.inexact, bus_tr.result);
      end
      release_start();
   endtask

   task automatic test_hold();
      int cyc; bit bs, to;
      logic [31:0] want; bit winx; int lat;
      ref_conv(32'h12345678, 1'b0, 1'b1, want, winx, lat);
      run_conv(32'h12345678, 1'b0, 1'b0, cyc, bs, to);
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         checks++;
         if (bus_rn.done !== 1'b1 || bus_rn.busy !== 1'b0 || bus_rn.result !== want) begin
            errors++;
            $display("FAIL hold[%0d]: got done %b busy %b result %h want 1 0 %h",
                     i, bus_rn.done, bus_rn.busy, bus_rn.result, want);
         end
      end
      release_start();
      checks++;
      if (bus_rn.done !== 1'b0 || bus_rn.result !== want) begin
         errors++;
         $display("FAIL hold_release: got done %b result %h want 0 %h", bus_rn.done, bus_rn.result, want);
      end
   endtask

   task automatic test_toggle();
      int cyc; bit bs, to;
      run_conv(32'h00000001, 1'b1, 1'b1, cyc, bs, to);
      checks++;
      if (to || cyc != 33 || bus_rn.result !== 32'h3F800000 || bus_tr.result !== 32'h3F800000) begin
         errors++;
         $display("FAIL toggle: got %h tr %h cycles %0d want 3f800000 33", bus_rn.result, bus_tr.result, cyc);
      end
      release_start();
   endtask

   task automatic test_abort_reset();
      int cyc; bit bs, to;
      @(negedge clk);
      int_in = 32'h00000001; is_signed = 1'b1; start = 1'b1;
      repeat (11) @(posedge clk);
      #1;
      checks++;
      if (bus_rn.busy !== 1'b1 || bus_rn.done !== 1'b0) begin
         errors++;
         $display("FAIL abort_busy: got busy %b done %b want 1 0", bus_rn.busy, bus_rn.done);
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if ({bus_rn.result, bus_rn.done, bus_rn.busy, bus_rn.inexact} !== 35'd0 ||
          {bus_tr.result, bus_tr.done, bus_tr.busy, bus_tr.inexact} !== 35'd0) begin
         errors++;
         $display("FAIL abort_reset: got %h/%b%b%b want all zero",
                  bus_rn.result, bus_rn.done, bus_rn.busy, bus_rn.inexact);
      end
      @(negedge clk); start = 1'b0;
      @(negedge clk); reset = 1'b0;
      run_conv(32'h00000064, 1'b0, 1'b0, cyc, bs, to);
      checks++;
      if (to || bus_rn.result !== 32'h42C80000 || bus_rn.inexact !== 1'b0) begin
         errors++;
         $display("FAIL abort_after: got %h inx %b want 42c80000 0", bus_rn.result, bus_rn.inexact);
      end
      release_start();
   endtask

   task automatic test_random();
      int cyc; bit bs, to;
      logic [31:0] x, w_rn, w_tr;
      bit sg, i_rn, i_tr;
      int lat, lat_tr;
      for (int n = 0; n < 200; n++) begin
         x  = $urandom >> $urandom_range(0, 31);
         sg = 1'($urandom_range(0, 1));
         if (sg && $urandom_range(0, 1) == 1) x = -x;
         ref_conv(x, sg, 1'b1, w_rn, i_rn, lat);
         ref_conv(x, sg, 1'b0, w_tr, i_tr, lat_tr);
         run_conv(x, sg, 1'b0, cyc, bs, to);
         checks++;
         if (to || cyc != lat || bs != (lat > 1)) begin
            errors++;
            $display("FAIL rand_latency x=%h s=%b: got %0d busy %b want %0d", x, sg, cyc, bs, lat);
         end
         checks++;
         if (bus_rn.result !== w_rn || bus_rn.inexact !== i_rn) begin
            errors++;
            $display("FAIL rand_rne x=%h s=%b: got %h inx %b want %h inx %b",
                     x, sg, bus_rn.result, bus_rn.inexact, w_rn, i_rn);
         end
         checks++;
         if (bus_tr.result !== w_tr || bus_tr.inexact !== i_tr) begin
            errors++;
            $display("FAIL rand_trunc x=%h s=%b: got %h inx %b want %h inx %b",
                     x, sg, bus_tr.result, bus_tr.inexact, w_tr, i_tr);
         end
         release_start();
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_directed();
      test_zero();
      test_hold();
      test_toggle();
      test_abort_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
